chicken_turn_ctrl: RTL and testbench

- Parametrised successor to the single-player game control FSM, for NUM_PLAYERS players on a circular track of TRACK_LEN tiles.
- Each turn: the active player keys in a target tile, then repeatedly requests flips. A match advances the player's chicken; a miss passes the turn.
- Keeps per-player positions and step counts internally, detects the winner, and handshakes with the external tile/reveal logic.

---
 rtl/chicken_pkg.sv | 41 ++++
 rtl/player_track_ctr.sv | 43 ++++
 rtl/chicken_turn_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_chicken_turn_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chicken_pkg.sv
// Shared constants, state encoding and helpers for the chicken race turn controller.
package chicken_pkg;

    localparam int unsigned DEF_NUM_PLAYERS = 4;
    localparam int unsigned DEF_KEY_W       = 4;
    localparam int unsigned DEF_TRACK_LEN   = 24;
    localparam int unsigned DEF_WIN_STEPS   = 24;
    localparam int unsigned DEF_TIMEOUT_CYC = 50000000;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SELECT    = 3'd1;
    localparam logic [2:0] S_ARM       = 3'd2;
    localparam logic [2:0] S_WAIT_FLIP = 3'd3;
    localparam logic [2:0] S_REVEAL    = 3'd4;
    localparam logic [2:0] S_ADVANCE   = 3'd5;
    localparam logic [2:0] S_NEXT      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    typedef enum logic [2:0] {
        StIdle     = S_IDLE,
        StSelect   = S_SELECT,
        StArm      = S_ARM,
        StWaitFlip = S_WAIT_FLIP,
        StReveal   = S_REVEAL,
        StAdvance  = S_ADVANCE,
        StNext     = S_NEXT,
        StDone     = S_DONE
    } state_e;

    // KEY_NONE test: true when the low w bits of k are all ones.
    function automatic logic key_none(logic [31:0] k, int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return &(k | ~mask);
    endfunction

    function automatic int unsigned step_w(int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/player_track_ctr.sv
// Per-player chicken state: wrapping track position and successful-advance count.
module player_track_ctr
    import chicken_pkg::*;
#(
    parameter int unsigned TRACK_LEN = DEF_TRACK_LEN,
    parameter int unsigned WIN_STEPS = DEF_WIN_STEPS,
    localparam int unsigned QW = $clog2(TRACK_LEN)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_init,
    input  logic          i_inc,
    input  logic [QW-1:0] i_init_pos,
    output logic [QW-1:0] o_pos,
    output logic          o_reached_win
);

    localparam int unsigned SW = step_w(WIN_STEPS);

    logic [QW-1:0] r_pos;
    logic [SW-1:0] r_steps;
    logic [QW-1:0] w_pos_inc;

    assign w_pos_inc = (r_pos == QW'(TRACK_LEN - 1)) ? '0 : r_pos + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos   <= i_init_pos;
            r_steps <= '0;
        end else if (i_init) begin
            r_pos   <= i_init_pos;
            r_steps <= '0;
        end else if (i_inc) begin
            r_pos   <= w_pos_inc;
            r_steps <= r_steps + 1'b1;
        end
    end

    assign o_pos = r_pos;
    // Flags that the next increment is the winning one, so the FSM can decide in ADVANCE.
    assign o_reached_win = (r_steps == SW'(WIN_STEPS - 1));

endmodule

// File: rtl/chicken_turn_ctrl.sv
// Turn controller for a multi-player chicken race on a circular track.
// Optional WAIT_FLIP timeout forfeit is enabled by defining CHICKEN_TURN_TIMEOUT_EN.
module chicken_turn_ctrl
    import chicken_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter int unsigned KEY_W       = DEF_KEY_W,
    parameter int unsigned TRACK_LEN   = DEF_TRACK_LEN,
    parameter int unsigned WIN_STEPS   = DEF_WIN_STEPS,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int unsigned PW = $clog2(NUM_PLAYERS),
    localparam int unsigned QW = $clog2(TRACK_LEN)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [KEY_W-1:0]          i_key,
    input  logic                      i_start,
    input  logic                      i_match_valid,
    input  logic                      i_match,
    output logic                      o_flip_req,
    output logic                      o_advance,
    output logic [KEY_W-1:0]          o_target,
    output logic [2:0]                o_state,
    output logic [PW-1:0]             o_cur_player,
    output logic [NUM_PLAYERS*QW-1:0] o_pos_flat,
    output logic [PW-1:0]             o_winner,
    output logic                      o_game_over
);

    state_e           r_state;
    state_e           w_state_d;
    logic [PW-1:0]    r_cur;
    logic [PW-1:0]    w_cur_d;
    logic [KEY_W-1:0] r_target;
    logic [KEY_W-1:0] w_target_d;
    logic [PW-1:0]    r_winner;
    logic [PW-1:0]    w_winner_d;
    logic             r_key_armed;
    logic             w_key_armed_d;

    logic                   w_key_idle;
    logic                   w_key_accept;
    logic                   w_timeout;
    logic                   w_reinit;
    logic                   w_adv_now;
    logic [NUM_PLAYERS-1:0] w_reached_win;

    assign w_key_idle   = key_none(32'(i_key), KEY_W);
    // A key counts once per press: it needs an idle sample since the last acceptance.
    assign w_key_accept = !w_key_idle && r_key_armed &&
                          ((r_state == StSelect) || (r_state == StWaitFlip));
    assign w_adv_now    = (r_state == StAdvance);

`ifdef CHICKEN_TURN_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= (r_state == StWaitFlip) ? r_to_cnt + 1'b1 : '0;
        end
    end

    assign w_timeout = (r_state == StWaitFlip) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_cur_d    = r_cur;
        w_target_d = r_target;
        w_winner_d = r_winner;
        w_reinit   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSelect;
                    w_cur_d   = '0;
                end
            end
            StSelect: begin
                if (w_key_accept) begin
                    w_target_d = i_key;
                    w_state_d  = StArm;
                end
            end
            StArm: begin
                if (w_key_idle) begin
                    w_state_d = StWaitFlip;
                end
            end
            StWaitFlip: begin
                if (w_key_accept) begin
                    w_state_d = StReveal;
                end else if (w_timeout) begin
                    w_state_d = StNext;
                end
            end
            StReveal: begin
                if (i_match_valid) begin
                    w_state_d = i_match ? StAdvance : StNext;
                end
            end
            StAdvance: begin
                if (w_reached_win[r_cur]) begin
                    w_state_d  = StDone;
                    w_winner_d = r_cur;
                end else begin
                    w_state_d = StArm;
                end
            end
            StNext: begin
                w_cur_d    = (r_cur == PW'(NUM_PLAYERS - 1)) ? '0 : r_cur + 1'b1;
                w_target_d = '0;
                w_state_d  = StSelect;
            end
            StDone: begin
                if (i_start) begin
                    w_reinit   = 1'b1;
                    w_winner_d = '0;
                    w_cur_d    = '0;
                    w_state_d  = StSelect;
                end
            end
        endcase
    end

    always_comb begin
        w_key_armed_d = r_key_armed;
        if (w_key_idle) begin
            w_key_armed_d = 1'b1;
        end else if (w_key_accept) begin
            w_key_armed_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cur       <= '0;
            r_target    <= '0;
            r_winner    <= '0;
            r_key_armed <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cur       <= w_cur_d;
            r_target    <= w_target_d;
            r_winner    <= w_winner_d;
            r_key_armed <= w_key_armed_d;
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        localparam logic [QW-1:0] INIT_POS = QW'(g * (TRACK_LEN / NUM_PLAYERS));

        player_track_ctr #(
            .TRACK_LEN (TRACK_LEN),
            .WIN_STEPS (WIN_STEPS)
        ) u_track (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_init        (w_reinit),
            .i_inc         (w_adv_now && (r_cur == PW'(g))),
            .i_init_pos    (INIT_POS),
            .o_pos         (o_pos_flat[g*QW +: QW]),
            .o_reached_win (w_reached_win[g])
        );
    end

    assign o_flip_req   = (r_state == StReveal);
    assign o_advance    = (r_state == StAdvance);
    assign o_game_over  = (r_state == StDone);
    assign o_state      = r_state;
    assign o_target     = r_target;
    assign o_cur_player = r_cur;
    assign o_winner     = r_winner;

endmodule

// File: tb/tb_chicken_turn_ctrl.sv
// Scoreboard bench: a 4-player and a 3-player controller share one input stream.
`timescale 1ns/1ps
module tb_chicken_turn_ctrl;

    localparam int unsigned TO = 8;
    localparam int unsigned QW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] key;
    logic       start, mv, match;

    logic        flip4, adv4, go4;
    logic [3:0]  tgt4;
    logic [2:0]  st4;
    logic [1:0]  cur4, win4;
    logic [11:0] pos4;

    logic        flip3, adv3, go3;
    logic [3:0]  tgt3;
    logic [2:0]  st3;
    logic [1:0]  cur3, win3;
    logic [8:0]  pos3;

    chicken_turn_ctrl #(
        .NUM_PLAYERS (4), .KEY_W (4), .TRACK_LEN (8), .WIN_STEPS (3), .TIMEOUT_CYC (TO)
    ) u_dut4 (
        .i_clk (clk), .i_rst_n (rst_n), .i_key (key), .i_start (start),
        .i_match_valid (mv), .i_match (match), .o_flip_req (flip4), .o_advance (adv4),
        .o_target (tgt4), .o_state (st4), .o_cur_player (cur4), .o_pos_flat (pos4),
        .o_winner (win4), .o_game_over (go4)
    );

    chicken_turn_ctrl #(
        .NUM_PLAYERS (3), .KEY_W (4), .TRACK_LEN (6), .WIN_STEPS (15), .TIMEOUT_CYC (TO)
    ) u_dut3 (
        .i_clk (clk), .i_rst_n (rst_n), .i_key (key), .i_start (start),
        .i_match_valid (mv), .i_match (match), .o_flip_req (flip3), .o_advance (adv3),
        .o_target (tgt3), .o_state (st3), .o_cur_player (cur3), .o_pos_flat (pos3),
        .o_winner (win3), .o_game_over (go3)
    );

    typedef struct {
        int player;
        int pos;
    } adv_t;

    int np[2] = '{4, 3};
    int tl[2] = '{8, 6};
    int ws[2] = '{3, 15};

    int   m_st[2], m_cur[2], m_tgt[2], m_win[2], m_tc[2];
    bit   m_armed[2];
    int   m_pos[2][4], m_steps[2][4];
    adv_t q4[$], q3[$];
    int   n_tests, n_fail;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_new_game(int d);
        for (int i = 0; i < np[d]; i++) begin
            m_pos[d][i]   = i * (tl[d] / np[d]);
            m_steps[d][i] = 0;
        end
        m_cur[d] = 0;
        m_win[d] = 0;
    endtask

    task automatic model_reset(int d);
        model_new_game(d);
        m_st[d]    = 0;
        m_tgt[d]   = 0;
        m_tc[d]    = 0;
        m_armed[d] = 1'b0;
    endtask

    task automatic model_tick(int d);
        bit   idle, acc, to;
        int   ns, p;
        adv_t e;
        idle = (key == 4'hF);
        acc  = !idle && m_armed[d] && (m_st[d] == 1 || m_st[d] == 3);
`ifdef CHICKEN_TURN_TIMEOUT_EN
        to = (m_st[d] == 3) && (m_tc[d] == TO - 1);
`else
        to = 1'b0;
`endif
        ns = m_st[d];
        p  = m_cur[d];
        case (m_st[d])
            0: if (start) begin ns = 1; m_cur[d] = 0; end
            1: if (acc) begin ns = 2; m_tgt[d] = int'(key); end
            2: if (idle) ns = 3;
            3: if (acc) ns = 4; else if (to) ns = 6;
            4: if (mv) begin
                ns = match ? 5 : 6;
                if (match) begin
                    e.player = p;
                    e.pos    = m_pos[d][p];
                    if (d == 0) q4.push_back(e);
                    else q3.push_back(e);
                end
            end
            5: begin
                m_pos[d][p] = (m_pos[d][p] + 1) % tl[d];
                m_steps[d][p]++;
                if (m_steps[d][p] == ws[d]) begin ns = 7; m_win[d] = p; end
                else ns = 2;
            end
            6: begin m_cur[d] = (p + 1) % np[d]; m_tgt[d] = 0; ns = 1; end
            7: if (start) begin model_new_game(d); ns = 1; end
            default: ns = 0;
        endcase
        m_tc[d]    = (m_st[d] == 3) ? m_tc[d] + 1 : 0;
        m_armed[d] = idle ? 1'b1 : (acc ? 1'b0 : m_armed[d]);
        m_st[d]    = ns;
    endtask

    task automatic compare_dut(string pfx, int d, logic [2:0] st, logic [1:0] cur,
                               logic [3:0] tgt, logic [11:0] pos, logic flip, logic go,
                               logic [1:0] win);
        logic [11:0] epos;
        epos = '0;
        for (int i = 0; i < np[d]; i++) epos |= 12'(m_pos[d][i]) << (i * QW);
        check_eq({pfx, "_state"}, 32'(st), 32'(m_st[d]));
        check_eq({pfx, "_cur"}, 32'(cur), 32'(m_cur[d]));
        check_eq({pfx, "_target"}, 32'(tgt), 32'(m_tgt[d]));
        check_eq({pfx, "_pos"}, 32'(pos), 32'(epos));
        check_eq({pfx, "_flip_req"}, 32'(flip), 32'(m_st[d] == 4));
        check_eq({pfx, "_game_over"}, 32'(go), 32'(m_st[d] == 7));
        check_eq({pfx, "_winner"}, 32'(win), 32'(m_win[d]));
    endtask

    task automatic compare_all();
        compare_dut("d4", 0, st4, cur4, tgt4, pos4, flip4, go4, win4);
        compare_dut("d3", 1, st3, cur3, tgt3, {3'b000, pos3}, flip3, go3, win3);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_tick(0);
            model_tick(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(logic [3:0] k, logic s, logic v, logic m, int n);
        key   = k;
        start = s;
        mv    = v;
        match = m;
        repeat (n) cycle();
    endtask

    task automatic select(logic [3:0] k);
        drive(k, 1'b0, 1'b0, 1'b0, 3);
        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
    endtask

    // Key held through the whole reveal and beyond: must yield only one flip.
    task automatic flip(logic [3:0] k, logic hit);
        drive(k, 1'b0, 1'b0, 1'b0, 3);
        drive(k, 1'b0, 1'b1, hit, 1);
        drive(k, 1'b0, 1'b0, 1'b0, 6);
        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
    endtask

    // match_valid already high when REVEAL is entered.
    task automatic flip_fast(logic [3:0] k);
        drive(k, 1'b0, 1'b1, 1'b1, 2);
        drive(k, 1'b0, 1'b0, 1'b0, 4);
        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
    endtask

    always @(negedge clk) begin
        adv_t e;
        if (rst_n && adv4) begin
            check_eq("d4_adv_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) begin
                e = q4.pop_front();
                check_eq("d4_adv_player", 32'(cur4), 32'(e.player));
                check_eq("d4_adv_pos", 32'(pos4[cur4*QW +: QW]), 32'(e.pos));
            end
        end
        if (rst_n && adv3) begin
            check_eq("d3_adv_expected", 32'(q3.size() > 0), 32'd1);
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check_eq("d3_adv_player", 32'(cur3), 32'(e.player));
                check_eq("d3_adv_pos", 32'(pos3[cur3*QW +: QW]), 32'(e.pos));
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        key     = 4'hF;
        start   = 1'b0;
        mv      = 1'b0;
        match   = 1'b0;
        model_reset(0);
        model_reset(1);
        repeat (2) cycle();
        rst_n = 1'b1;

        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
        drive(4'hF, 1'b1, 1'b0, 1'b0, 1);
        select(4'h5);
        flip(4'h2, 1'b1);
        flip(4'h3, 1'b0);
        select(4'h7);
        flip(4'h2, 1'b0);
        select(4'h1);
        flip(4'h2, 1'b1);
        flip_fast(4'h8);
        flip(4'h4, 1'b0);
        select(4'h9);
        flip(4'h2, 1'b1);
        flip(4'h2, 1'b1);
        flip(4'h4, 1'b0);
        select(4'h6);
        flip(4'h2, 1'b1);
        flip(4'h2, 1'b1);

        // 4-player game is over; start restarts it while the other unit ignores start.
        drive(4'hF, 1'b0, 1'b0, 1'b0, 3);
        drive(4'hF, 1'b1, 1'b0, 1'b0, 1);
        drive(4'hF, 1'b0, 1'b0, 1'b0, 1);
        select(4'h4);
        drive(4'h2, 1'b0, 1'b0, 1'b0, 2);

        #2;
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
        rst_n = 1'b1;

        drive(4'hF, 1'b0, 1'b0, 1'b0, 2);
        drive(4'hF, 1'b1, 1'b0, 1'b0, 1);
        select(4'h3);
        drive(4'hF, 1'b0, 1'b0, 1'b0, 12);
        flip(4'h2, 1'b0);

        check_eq("d4_sb_empty", 32'(q4.size()), 32'd0);
        check_eq("d3_sb_empty", 32'(q3.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
